// File: rtl/hpsfpga_spi_shifter_pkg.sv
// Shared definitions for the HPS-to-FPGA SPI shifter.
// Holds the Avalon-MM register addresses, the STATUS / CONTROL bit
// positions and the shift-engine state encoding.
package hpsfpga_spi_pkg;

  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_TX     = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RX     = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_BUSY     = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVERRUN  = 2;

  localparam int CTRL_IRQ_EN = 16;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

endpackage

// File: rtl/hpsfpga_spi_shifter_if.sv
// Avalon-MM register port of the SPI shifter.
//   address    : word address
//   chipselect : access select
//   write_n    : write strobe, active low (a select with write_n high is a read)
//   writedata  : write data
//   readdata   : read data, combinational from address
// master modport is the HPS side, slave modport is the shifter.
interface hpsfpga_spi_shifter_if;
  import hpsfpga_spi_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/hpsfpga_spi_clkgen.sv
// Half-period tick generator.
//   clk, reset : system clock, synchronous active-high reset
//   en         : count while high; count is held at zero while low, so it
//                restarts cleanly on every enable rise
//   div        : half-period is div+1 cycles
//   tick       : one-cycle pulse on the last cycle of each half-period
module hpsfpga_spi_clkgen
  import hpsfpga_spi_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  assign tick = en && (cnt == div);

  // Restarting on tick keeps cnt within 0..div, never wrapping.
  always_ff @(posedge clk) begin
    if (reset || !en || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hpsfpga_spi_shifter.sv
// SPI master (mode 0, MSB first) behind an Avalon-MM slave.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : register port (TXDATA / RXDATA / STATUS / CONTROL)
//   sclk       : SPI clock, idle low
//   mosi       : SPI data out, MSB of the TX shift register
//   miso       : SPI data in, already synchronous to clk
//   ss_n       : slave select, low for the whole transfer
//   irq        : level interrupt, irq_en & rx_valid
module hpsfpga_spi_shifter
  import hpsfpga_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  hpsfpga_spi_shifter_if.slave  bus,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ss_n,
  output logic                  irq
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rxdata;
  logic [DIV_WIDTH-1:0]  div, div_lat;
  logic [BW-1:0]         bit_cnt;
  logic                  rx_valid, overrun, irq_en, tick, busy;
  logic                  wr, tx_wr, tx_start, sts_wr, ctrl_wr, last_bit, done;
  logic                  unused_wd;

  assign wr       = bus.chipselect && !bus.write_n;
  assign tx_wr    = wr && (bus.address == ADDR_TX);
  assign sts_wr   = wr && (bus.address == ADDR_STATUS);
  assign ctrl_wr  = wr && (bus.address == ADDR_CTRL);
  assign tx_start = tx_wr && (state == IDLE);
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH));
  assign done     = (state == LOW) && tick && last_bit;
  assign busy     = !ss_n;
  assign mosi     = tx_sr[DATA_WIDTH-1];
  assign irq      = irq_en && rx_valid;
  assign unused_wd = ^bus.writedata;

  hpsfpga_spi_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .en    (state != IDLE),
    .div   (div_lat),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tx_start) state_nx = SETUP;
      SETUP:   if (tick)     state_nx = HIGH;
      HIGH:    if (tick)     state_nx = LOW;
      LOW:     if (tick)     state_nx = last_bit ? IDLE : HIGH;
      default:               state_nx = IDLE;
    endcase
  end

  // Pins are registered from the next state so they change exactly on the
  // state edge and cannot glitch on the state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk <= 1'b0;
      ss_n <= 1'b1;
    end else begin
      sclk <= (state_nx == HIGH);
      ss_n <= (state_nx == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      rxdata   <= '0;
      bit_cnt  <= '0;
      div_lat  <= '0;
      div      <= DIV_WIDTH'(DEFAULT_DIV);
      irq_en   <= 1'b0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (tx_start) begin
        tx_sr   <= bus.writedata[DATA_WIDTH-1:0];
        div_lat <= div;
        bit_cnt <= '0;
      end
      // miso is captured as sclk rises; the slave holds it stable across it.
      if (state != HIGH && state_nx == HIGH)
        rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
      if (state == HIGH && state_nx == LOW) begin
        tx_sr   <= tx_sr << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (done) rxdata <= rx_sr;

      // Set beats a same-cycle write-one-to-clear.
      if (done)                                    rx_valid <= 1'b1;
      else if (sts_wr && bus.writedata[ST_RX_VALID]) rx_valid <= 1'b0;
      if (tx_wr && !tx_start)                      overrun  <= 1'b1;
      else if (sts_wr && bus.writedata[ST_OVERRUN])  overrun  <= 1'b0;

      if (ctrl_wr) begin
        div    <= bus.writedata[DIV_WIDTH-1:0];
        irq_en <= bus.writedata[CTRL_IRQ_EN];
      end
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_RX: bus.readdata[DATA_WIDTH-1:0] = rxdata;
      ADDR_STATUS: begin
        bus.readdata[ST_BUSY]     = busy;
        bus.readdata[ST_RX_VALID] = rx_valid;
        bus.readdata[ST_OVERRUN]  = overrun;
      end
      ADDR_CTRL: begin
        bus.readdata[DIV_WIDTH-1:0] = div;
        bus.readdata[CTRL_IRQ_EN]   = irq_en;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hpsfpga_spi_shifter.sv
// Directed bench for hpsfpga_spi_shifter. Stimulus pushes expected register
// reads, pin probes and per-transfer pin statistics into queues; a monitor
// on the falling edge pops and compares as the DUT presents them.
module tb_hpsfpga_spi_shifter;
  import hpsfpga_spi_pkg::*;

  typedef struct {string name; logic [31:0] exp;} chk_t;
  typedef struct {string name; int cycles; int rises; logic [31:0] bits; int hi;} xfer_t;

  logic clk = 1'b0;
  logic reset;
  logic sclk, mosi, miso, ss_n, irq;
  logic loop = 1'b1, miso_val = 1'b0, probe = 1'b0;

  chk_t  rd_q[$], pin_q[$];
  xfer_t xf_q[$];
  int    n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  hpsfpga_spi_shifter_if bus();

  assign miso = loop ? mosi : miso_val;

  hpsfpga_spi_shifter #(.DATA_WIDTH(8), .DIV_WIDTH(16), .DEFAULT_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .ss_n  (ss_n),
    .irq   (irq)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.exp = exp;
    rd_q.push_back(c);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
  endtask

  // Expected pins packed as {irq, ss_n, sclk, mosi}.
  task automatic pin(input string name, input logic [3:0] exp);
    chk_t c;
    c.name = name; c.exp = {28'd0, exp};
    pin_q.push_back(c);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic expect_xfer(input string name, input int cyc, input int rises,
                             input logic [31:0] bits, input int hi);
    xfer_t x;
    x.name = name; x.cycles = cyc; x.rises = rises; x.bits = bits; x.hi = hi;
    xf_q.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (ss_n !== 1'b1 && i < 2000) begin @(posedge clk); #1; i++; end
    if (ss_n !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: ss_n still 0x%0h after %0d cycles, expected 1", name, ss_n, i);
    end
  endtask

  // Monitor
  initial begin
    int lowc, rises, hi, run;
    logic [31:0] bits;
    logic ss_prev, sc_prev;
    chk_t c;
    xfer_t x;
    lowc = 0; rises = 0; hi = 0; run = 0; bits = '0; ss_prev = 1'b1; sc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.chipselect === 1'b1 && bus.write_n === 1'b1) begin
        if (rd_q.size() == 0) check("rd_unexpected", bus.readdata, 32'hDEAD_BEEF);
        else begin c = rd_q.pop_front(); check(c.name, bus.readdata, c.exp); end
      end
      if (probe) begin
        if (pin_q.size() == 0) check("pin_unexpected", 32'h0, 32'hDEAD_BEEF);
        else begin c = pin_q.pop_front(); check(c.name, {28'd0, irq, ss_n, sclk, mosi}, c.exp); end
      end
      if (ss_n === 1'b0) begin
        lowc++;
        if (sclk === 1'b1) run++;
        if (sclk === 1'b1 && sc_prev === 1'b0) begin rises++; bits = {bits[30:0], mosi}; end
        if (sclk === 1'b0 && sc_prev === 1'b1 && hi == 0) hi = run;
      end else if (ss_n === 1'b1 && ss_prev === 1'b0) begin
        if (xf_q.size() == 0) check("xfer_unexpected", 32'(lowc), 32'h0);
        else begin
          x = xf_q.pop_front();
          check({x.name, "_cycles"}, 32'(lowc),  32'(x.cycles));
          check({x.name, "_rises"},  32'(rises), 32'(x.rises));
          check({x.name, "_mosi"},   bits,       x.bits);
          check({x.name, "_hi_len"}, 32'(hi),    32'(x.hi));
        end
        lowc = 0; rises = 0; hi = 0; run = 0; bits = '0;
      end
      ss_prev = ss_n;
      sc_prev = sclk;
    end
  end

  initial begin
    reset = 1'b1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;
    idle(3);
    reset = 1'b0;

    // Reset state
    pin("rst_pins", 4'h4);
    rd("rst_status", ADDR_STATUS, 32'h0);
    rd("rst_ctrl",   ADDR_CTRL,   32'h4);
    rd("rst_rx",     ADDR_RX,     32'h0);

    // div=0, loopback, 0xA5: 17 cycles, 8 rises
    wr(ADDR_CTRL, 32'h0);
    expect_xfer("a5", 17, 8, 32'hA5, 1);
    wr(ADDR_TX, 32'hA5);
    rd("a5_busy", ADDR_STATUS, 32'h1);
    wait_idle("a5");
    rd("a5_rx",     ADDR_RX,     32'hA5);
    rd("a5_status", ADDR_STATUS, 32'h2);
    wr(ADDR_STATUS, 32'h2);
    rd("a5_w1c",    ADDR_STATUS, 32'h0);

    // div=3, miso held 1, 0x3C: 68 cycles, 4-cycle half-periods
    loop = 1'b0; miso_val = 1'b1;
    wr(ADDR_CTRL, 32'h3);
    expect_xfer("3c", 68, 8, 32'h3C, 4);
    wr(ADDR_TX, 32'h3C);
    wait_idle("3c");
    rd("3c_rx", ADDR_RX, 32'hFF);
    wr(ADDR_STATUS, 32'h2);

    // Overrun: second write 5 cycles later dropped; then a write in the
    // first idle cycle after completion is accepted.
    loop = 1'b1;
    wr(ADDR_CTRL, 32'h0);
    expect_xfer("x11", 17, 8, 32'h11, 1);
    wr(ADDR_TX, 32'h11);
    idle(4);
    wr(ADDR_TX, 32'h22);
    wait_idle("x11");
    expect_xfer("x5a", 17, 8, 32'h5A, 1);
    wr(ADDR_TX, 32'h5A);
    wait_idle("x5a");
    rd("ovr_status", ADDR_STATUS, 32'h6);
    rd("ovr_rx",     ADDR_RX,     32'h5A);
    wr(ADDR_STATUS, 32'h4);
    rd("ovr_w1c",    ADDR_STATUS, 32'h2);

    // Interrupt
    wr(ADDR_STATUS, 32'h2);
    wr(ADDR_CTRL, 32'h1_0000);
    rd("irq_ctrl", ADDR_CTRL, 32'h1_0000);
    expect_xfer("x81", 17, 8, 32'h81, 1);
    wr(ADDR_TX, 32'h81);
    wait_idle("x81");
    pin("irq_set", 4'hC);
    wr(ADDR_STATUS, 32'h2);
    pin("irq_clr", 4'h4);
    wr(ADDR_CTRL, 32'h0);
    expect_xfer("x42", 17, 8, 32'h42, 1);
    wr(ADDR_TX, 32'h42);
    wait_idle("x42");
    pin("irq_off", 4'h4);
    rd("irq_off_status", ADDR_STATUS, 32'h2);

    // Reset 10 cycles into a div=1 transfer
    wr(ADDR_CTRL, 32'h1);
    expect_xfer("abort", 10, 2, 32'h3, 2);
    wr(ADDR_TX, 32'hC3);
    idle(9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pin("abort_pins", 4'h4);
    rd("abort_status", ADDR_STATUS, 32'h0);
    rd("abort_ctrl",   ADDR_CTRL,   32'h4);
    rd("abort_rx",     ADDR_RX,     32'h0);

    // CONTROL write while busy only affects the next transfer
    wr(ADDR_CTRL, 32'h0);
    expect_xfer("x96", 17, 8, 32'h96, 1);
    wr(ADDR_TX, 32'h96);
    idle(2);
    wr(ADDR_CTRL, 32'h7);
    wait_idle("x96");
    rd("div7_ctrl", ADDR_CTRL, 32'h7);
    expect_xfer("x69", 136, 8, 32'h69, 8);
    wr(ADDR_TX, 32'h69);
    wait_idle("x69");
    rd("x69_rx",     ADDR_RX,     32'h69);
    rd("x69_status", ADDR_STATUS, 32'h2);

    idle(5);
    check("rd_q_left",  32'(rd_q.size()),  32'h0);
    check("pin_q_left", 32'(pin_q.size()), 32'h0);
    check("xf_q_left",  32'(xf_q.size()),  32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
